fc_stream_selector: RTL and testbench

// - N-source fast-command (FC) stream selector; successor to the single-pair FC mux.
// - Takes per-source DDR capture pairs (rise/fall) already sampled on the 320 MHz FC clock.
// - Per-source edge select and invert; activity monitoring per source.
// - Manual or automatic-failover source selection.
// - Every source switch emits a clean idle pattern, so downstream word alignment is never fed a spliced stream.

---
 rtl/fc_stream_selector.sv | 91 +++++++++
 tb/tb_fc_stream_selector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_selector.sv
// fc_stream_selector: N-source fast-command selector with per-source edge/invert, activity monitor, failover and idle insertion on every switch
module fc_stream_selector #(
  parameter int          N_SRC     = 2,
  parameter int          SEL_W     = $clog2(N_SRC),
  parameter int          WINDOW    = 4096,
  parameter int          MIN_TRANS = 16,
  parameter int          IDLE_LEN  = 8,
  parameter logic [31:0] IDLE_WORD = 32'hAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] fc_rise,
  input  logic [N_SRC-1:0] fc_fall,
  input  logic [N_SRC-1:0] cfg_edgesel,
  input  logic [N_SRC-1:0] cfg_invert,
  input  logic [SEL_W-1:0] cfg_src_sel,
  input  logic             cfg_auto,
  output logic [N_SRC-1:0] src_active,
  output logic [SEL_W-1:0] active_src,
  output logic             switching,
  output logic [15:0]      switch_count,
  output logic             fc_out
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int TR_W  = $clog2(MIN_TRANS + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state;
  logic [N_SRC-1:0] s, s_prev, tr;
  logic [WIN_W-1:0] win_cnt;
  logic [TR_W-1:0]  trans_cnt [N_SRC];
  logic [4:0]       idle_idx;
  logic [SEL_W-1:0] sel, low, target;
  logic             win_end;

  assign tr      = s ^ s_prev;
  assign win_end = win_cnt == WIN_W'(WINDOW - 1);
  assign sel     = {1'b0, cfg_src_sel} < (SEL_W + 1)'(N_SRC) ? cfg_src_sel : '0;

  // With no active source the fallback is the current source, so no switch happens
  always_comb begin
    low = active_src;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (src_active[i]) low = SEL_W'(i);
    target = !cfg_auto || src_active[sel] ? sel : low;
  end

  always_ff @(posedge clk)
    if (reset) begin
      s          <= '0;
      s_prev     <= '0;
      win_cnt    <= '0;
      src_active <= '0;
      for (int i = 0; i < N_SRC; i++) trans_cnt[i] <= '0;
    end else begin
      s       <= ((cfg_edgesel & fc_fall) | (~cfg_edgesel & fc_rise)) ^ cfg_invert;
      s_prev  <= s;
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      for (int i = 0; i < N_SRC; i++) begin
        trans_cnt[i] <= win_end ? '0 :
                        trans_cnt[i] == TR_W'(MIN_TRANS) ? trans_cnt[i] : trans_cnt[i] + TR_W'(tr[i]);
        if (win_end) src_active[i] <= 32'(trans_cnt[i]) + 32'(tr[i]) >= 32'(MIN_TRANS);
      end
    end

  // The flush length is fixed once started; the new source is taken from target on its last cycle
  always_ff @(posedge clk)
    if (reset) begin
      state        <= RUN;
      idle_idx     <= '0;
      active_src   <= '0;
      switching    <= 1'b0;
      switch_count <= '0;
      fc_out       <= 1'b0;
    end else if (state == RUN) begin
      fc_out <= s[active_src];
      if (target != active_src) begin
        state        <= FLUSH;
        idle_idx     <= '0;
        switching    <= 1'b1;
        switch_count <= switch_count + {15'd0, ~&switch_count};
      end
    end else begin
      fc_out   <= IDLE_WORD[5'(IDLE_LEN - 1) - idle_idx];
      idle_idx <= idle_idx + 1'b1;
      if (idle_idx == 5'(IDLE_LEN - 1)) begin
        active_src <= target;
        switching  <= 1'b0;
        state      <= RUN;
      end
    end
endmodule

// File: tb/tb_fc_stream_selector.sv
// tb_fc_stream_selector: randomized scoreboard bench against a queue-based reference model of the selector
module tb_fc_stream_selector;
  localparam int          N   = 3;
  localparam int          SW  = 2;
  localparam int          WIN = 64;
  localparam int          MT  = 16;
  localparam int          IL  = 8;
  localparam logic [31:0] IW  = 32'hAC;

  logic          clk = 1'b0, reset = 1'b1, cfg_auto = 1'b0;
  logic [N-1:0]  fc_rise = '0, fc_fall = '0, cfg_edgesel = '0, cfg_invert = '0;
  logic [SW-1:0] cfg_src_sel = '0;
  logic [N-1:0]  src_active;
  logic [SW-1:0] active_src;
  logic          switching, fc_out;
  logic [15:0]   switch_count;

  always #5 clk = ~clk;

  fc_stream_selector #(.N_SRC(N), .SEL_W(SW), .WINDOW(WIN), .MIN_TRANS(MT), .IDLE_LEN(IL), .IDLE_WORD(IW)) dut (
    .clk(clk), .reset(reset), .fc_rise(fc_rise), .fc_fall(fc_fall), .cfg_edgesel(cfg_edgesel),
    .cfg_invert(cfg_invert), .cfg_src_sel(cfg_src_sel), .cfg_auto(cfg_auto), .src_active(src_active),
    .active_src(active_src), .switching(switching), .switch_count(switch_count), .fc_out(fc_out));

  typedef struct packed {
    logic [N-1:0]  act;
    logic [SW-1:0] src;
    logic          sw;
    logic [15:0]   cnt;
    logic          fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   compared = 0, mismatched = 0, ncyc = 0;

  // Reference model: integer transition tallies per window and a queue of pending idle bits
  logic [N-1:0] m_s = '0, m_sprev = '0, m_act = '0;
  int           m_trans[N];
  int           m_win = 0, m_src = 0, m_cnt = 0;
  logic         m_fc = 1'b0, m_sw = 1'b0;
  bit           m_idle[$];

  int           mode[N];
  logic [N-1:0] src_bit = '0;

  task automatic model_step();
    int sel, tgt;
    logic [N-1:0] tr;
    if (reset) begin
      m_s = '0; m_sprev = '0; m_act = '0; m_win = 0; m_src = 0; m_cnt = 0; m_fc = 1'b0; m_sw = 1'b0;
      m_idle.delete();
      for (int i = 0; i < N; i++) m_trans[i] = 0;
    end else begin
      sel = int'(cfg_src_sel) < N ? int'(cfg_src_sel) : 0;
      tgt = sel;
      if (cfg_auto && !m_act[sel]) begin
        tgt = m_src;
        for (int i = N - 1; i >= 0; i--) if (m_act[i]) tgt = i;
      end
      if (m_idle.size() == 0) begin
        m_fc = m_s[m_src];
        if (tgt != m_src) begin
          for (int k = IL - 1; k >= 0; k--) m_idle.push_back(IW[k]);
          m_sw = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        m_fc = m_idle.pop_front();
        if (m_idle.size() == 0) begin
          m_src = tgt;
          m_sw  = 1'b0;
        end
      end
      tr = m_s ^ m_sprev;
      for (int i = 0; i < N; i++)
        if (m_win == WIN - 1) begin
          m_act[i]   = (m_trans[i] + int'(tr[i])) >= MT;
          m_trans[i] = 0;
        end else m_trans[i] += int'(tr[i]);
      m_win   = (m_win + 1) % WIN;
      m_sprev = m_s;
      for (int i = 0; i < N; i++) m_s[i] = (cfg_edgesel[i] ? fc_fall[i] : fc_rise[i]) ^ cfg_invert[i];
    end
    exp_q.push_back({m_act, SW'(m_src), m_sw, 16'(m_cnt), m_fc});
  endtask

  // Modes: 0 stuck, 1 toggle every cycle, 2 random, 3 exactly 15 toggles per window, 4 exactly 16
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      case (mode[i])
        1: src_bit[i] = ~src_bit[i];
        2: src_bit[i] = 1'($urandom);
        3: if (m_win % 4 == 0 && m_win != 0) src_bit[i] = ~src_bit[i];
        4: if (m_win % 4 == 0) src_bit[i] = ~src_bit[i];
        default: ;
      endcase
      fc_rise[i] = cfg_edgesel[i] ? 1'($urandom) : src_bit[i];
      fc_fall[i] = cfg_edgesel[i] ? src_bit[i] : 1'($urandom);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {src_active, active_src, switching, switch_count, fc_out};
      ncyc++;
      compared++;
      if (mon_a !== mon_e) begin
        mismatched++;
        $display("FAIL cycle %0d: dut act=%b src=%0d sw=%b cnt=%0d fc=%b, expected act=%b src=%0d sw=%b cnt=%0d fc=%b",
                 ncyc, mon_a.act, mon_a.src, mon_a.sw, mon_a.cnt, mon_a.fc,
                 mon_e.act, mon_e.src, mon_e.sw, mon_e.cnt, mon_e.fc);
      end
    end
  end

  initial begin
    int saved_cnt;
    mode = '{1, 0, 2};
    run(3);
    reset = 1'b0;
    check("reset_count", int'(switch_count), 0);
    cfg_edgesel = 3'b010;
    run(40);
    check("manual_src0", int'(active_src), 0);
    cfg_invert = 3'b001;
    run(20);
    cfg_src_sel = 2'd1;
    run(30);
    check("switch_to_1_src", int'(active_src), 1);
    check("switch_to_1_count", int'(switch_count), 1);
    cfg_src_sel = 2'd3;
    run(30);
    check("sel3_as_0_src", int'(active_src), 0);
    check("sel3_as_0_count", int'(switch_count), 2);
    cfg_invert = '0; cfg_edgesel = '0; mode = '{3, 4, 0};
    run(3 * WIN);
    check("activity_15_vs_16", int'(src_active), 3'b010);
    check("activity_manual_count", int'(switch_count), 2);
    cfg_auto = 1'b1; cfg_src_sel = 2'd0; mode = '{1, 1, 0};
    run(3 * WIN);
    check("auto_pref_active", int'(src_active), 3'b011);
    check("auto_pref_src", int'(active_src), 0);
    mode[0] = 0;
    run(3 * WIN);
    check("failover_act", int'(src_active), 3'b010);
    check("failover_src", int'(active_src), 1);
    mode[0] = 1;
    run(3 * WIN);
    check("failback_src", int'(active_src), 0);
    saved_cnt = m_cnt;
    mode = '{0, 0, 0};
    run(3 * WIN);
    check("none_active_act", int'(src_active), 0);
    check("none_active_src", int'(active_src), 0);
    check("none_active_count", int'(switch_count), saved_cnt);
    cfg_auto = 1'b0; cfg_src_sel = 2'd2; mode = '{1, 1, 1};
    run(3);
    check("midflush_switching", int'(switching), 1);
    reset = 1'b1;
    run(1);
    check("reset_flush_switching", int'(switching), 0);
    check("reset_flush_count", int'(switch_count), 0);
    check("reset_flush_src", int'(active_src), 0);
    reset = 1'b0; cfg_src_sel = 2'd3;
    run(20);
    check("post_reset_sel3_count", int'(switch_count), 0);
    for (int r = 0; r < 40; r++) begin
      cfg_src_sel = SW'($urandom_range(0, 3));
      cfg_auto    = 1'($urandom);
      cfg_edgesel = N'($urandom);
      cfg_invert  = N'($urandom);
      for (int i = 0; i < N; i++) mode[i] = int'($urandom_range(0, 4));
      run(int'($urandom_range(5, 40)));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
